eth_probe_gen: RTL and testbench

- Parametrised successor to the single-port test frame sender that drives a gig MAC TX client interface.
- Generates delay-probe Ethernet frames with the following run controls:
  - programmable length
  - programmable inter-frame gap
  - programmable frame count, or continuous mode
  - start/stop control
- Each frame embeds a sequence number and a transmit timestamp so the RX side can measure latency and loss.
- Sits between the test-control registers and one gig_eth_mac TX client port; CRC is appended by the MAC.

---
 rtl/eth_probe_gen_pkg.sv | 21 ++
 rtl/eth_probe_gen_if.sv | 21 ++
 rtl/eth_probe_byte_sel.sv | 51 +++++
 rtl/eth_probe_gen.sv | 182 ++++++++++++++++++
 tb/tb_eth_probe_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_probe_gen_pkg.sv
// Shared constants and state encoding for the delay-probe frame generator.
// Frame layout offsets are byte positions from the start of the frame.
package eth_probe_gen_pkg;

    localparam int MIN_LEN       = 60;
    localparam int MAX_STD_LEN   = 1514;
    localparam int MAX_JUMBO_LEN = 9014;

    localparam int OFS_SRC  = 6;
    localparam int OFS_TYPE = 12;
    localparam int OFS_SEQ  = 14;
    localparam int OFS_TS   = 18;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        SEND,
        GAP
    } state_t;

endpackage

// File: rtl/eth_probe_gen_if.sv
// Gig MAC TX client port: byte stream with a first-byte acknowledge.
// The generator is the master; the MAC is the slave.
interface eth_probe_gen_if;

    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack;

    modport master (
        output mac_tx_data,
        output mac_tx_dvld,
        input  mac_tx_ack
    );

    modport slave (
        input  mac_tx_data,
        input  mac_tx_dvld,
        output mac_tx_ack
    );

endinterface

// File: rtl/eth_probe_byte_sel.sv
// Combinational frame byte lookup: header fields big-endian,
// payload bytes carry the low byte of their own index.
module eth_probe_byte_sel
    import eth_probe_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0002_0000_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          TS_W      = 32,
    parameter int          LEN_W     = 14,
    parameter int          CNT_W     = 32
) (
    input  logic [LEN_W-1:0] i_idx,
    input  logic [CNT_W-1:0] i_seq,
    input  logic [TS_W-1:0]  i_ts,
    output logic [7:0]       o_byte
);

    localparam int TS_B = TS_W / 8;

    logic [31:0] w_i;
    logic [31:0] w_seq32;

    assign w_i = 32'(i_idx);

    // The sequence field is always 32 bits on the wire.
    if (CNT_W >= 32) begin : g_seq_trunc
        assign w_seq32 = i_seq[31:0];
    end else begin : g_seq_ext
        assign w_seq32 = {{(32-CNT_W){1'b0}}, i_seq};
    end

    always_comb begin
        o_byte = i_idx[7:0];
        unique case (1'b1)
            (w_i < OFS_SRC):
                o_byte = 8'(DST_MAC >> (8 * (OFS_SRC - 1 - w_i)));
            (w_i >= OFS_SRC && w_i < OFS_TYPE):
                o_byte = 8'(SRC_MAC >> (8 * (OFS_TYPE - 1 - w_i)));
            (w_i >= OFS_TYPE && w_i < OFS_SEQ):
                o_byte = 8'(ETHERTYPE >> (8 * (OFS_SEQ - 1 - w_i)));
            (w_i >= OFS_SEQ && w_i < OFS_TS):
                o_byte = 8'(w_seq32 >> (8 * (OFS_TS - 1 - w_i)));
            (w_i >= OFS_TS && w_i < OFS_TS + TS_B):
                o_byte = 8'(i_ts >> (8 * (OFS_TS + TS_B - 1 - w_i)));
            default:
                o_byte = i_idx[7:0];
        endcase
    end

endmodule

// File: rtl/eth_probe_gen.sv
// Delay-probe frame generator for one gig MAC TX client port.
// Frames carry a sequence number and the transmit timestamp.
module eth_probe_gen
    import eth_probe_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0002_0000_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          TS_W      = 32,
    parameter int          LEN_W     = 14,
    parameter int          GAP_W     = 16,
    parameter int          CNT_W     = 32
) (
    input  logic              tx_clk,
    input  logic              reset_n,
    input  logic              conf_tx_en,
    input  logic              conf_tx_jumbo_en,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [CNT_W-1:0]  cfg_frame_count,
    input  logic [TS_W-1:0]   timestamp,
    eth_probe_gen_if.master   mac,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frames_sent
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_count;
    logic [LEN_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gcnt;
    logic [CNT_W-1:0] r_seq;
    logic [CNT_W-1:0] r_frames;
    logic [TS_W-1:0]  r_ts;
    logic [7:0]       r_data;
    logic             r_dvld;
    logic             r_busy;
    logic             r_done;
    logic             r_stop_pend;

    logic [LEN_W-1:0] w_len;
    logic [GAP_W-1:0] w_gap;
    logic [LEN_W-1:0] w_nidx;
    logic [7:0]       w_byte;
    logic             w_stop_req;
    logic             w_last_frame;

    always_comb begin
        w_len = cfg_frame_len;
        if (32'(cfg_frame_len) < 32'(MIN_LEN))
            w_len = LEN_W'(MIN_LEN);
        else if (conf_tx_jumbo_en && 32'(cfg_frame_len) > 32'(MAX_JUMBO_LEN))
            w_len = LEN_W'(MAX_JUMBO_LEN);
        else if (!conf_tx_jumbo_en && 32'(cfg_frame_len) > 32'(MAX_STD_LEN))
            w_len = LEN_W'(MAX_STD_LEN);
    end

    assign w_gap = (cfg_gap == '0) ? GAP_W'(1) : cfg_gap;

    // Losing TX enable mid-run drains like an explicit stop.
    assign w_stop_req   = r_stop_pend | stop | ~conf_tx_en;
    assign w_last_frame = (r_count != '0)
                       && (r_frames + CNT_W'(1) == r_count);

    // Data is registered, so look up the byte that goes out next cycle.
    always_comb begin
        w_nidx = '0;
        unique case (r_state)
            WAIT_ACK: w_nidx = LEN_W'(1);
            SEND:     w_nidx = r_idx + LEN_W'(1);
            default:  w_nidx = '0;
        endcase
    end

    eth_probe_byte_sel #(
        .DST_MAC   (DST_MAC),
        .SRC_MAC   (SRC_MAC),
        .ETHERTYPE (ETHERTYPE),
        .TS_W      (TS_W),
        .LEN_W     (LEN_W),
        .CNT_W     (CNT_W)
    ) u_byte_sel (
        .i_idx  (w_nidx),
        .i_seq  (r_seq),
        .i_ts   (r_ts),
        .o_byte (w_byte)
    );

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_gap       <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_gcnt      <= '0;
            r_seq       <= '0;
            r_frames    <= '0;
            r_ts        <= '0;
            r_data      <= '0;
            r_dvld      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && w_stop_req)
                r_stop_pend <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (start && conf_tx_en && !stop) begin
                        r_len       <= w_len;
                        r_gap       <= w_gap;
                        r_count     <= cfg_frame_count;
                        r_frames    <= '0;
                        r_seq       <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_dvld      <= 1'b1;
                        r_data      <= w_byte;
                        r_stop_pend <= 1'b0;
                        r_state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (mac.mac_tx_ack) begin
                        r_ts    <= timestamp;
                        r_idx   <= LEN_W'(1);
                        r_data  <= w_byte;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (r_idx == r_len - LEN_W'(1)) begin
                        r_frames <= r_frames + CNT_W'(1);
                        r_seq    <= r_seq + CNT_W'(1);
                        r_dvld   <= 1'b0;
                        r_data   <= '0;
                        if (w_stop_req || w_last_frame) begin
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_stop_pend <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_gcnt  <= r_gap - GAP_W'(1);
                            r_state <= GAP;
                        end
                    end else begin
                        r_idx  <= r_idx + LEN_W'(1);
                        r_data <= w_byte;
                    end
                end
                GAP: begin
                    if (w_stop_req) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_gcnt == '0) begin
                        r_idx   <= '0;
                        r_dvld  <= 1'b1;
                        r_data  <= w_byte;
                        r_state <= WAIT_ACK;
                    end else begin
                        r_gcnt <= r_gcnt - GAP_W'(1);
                    end
                end
            endcase
        end
    end

    assign mac.mac_tx_data = r_data;
    assign mac.mac_tx_dvld = r_dvld;
    assign busy            = r_busy;
    assign done            = r_done;
    assign frames_sent     = r_frames;

endmodule

// File: tb/tb_eth_probe_gen.sv
// Directed and randomized bench for eth_probe_gen with a MAC responder
// and a frame-level reference model.
module tb_eth_probe_gen;

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0002_0000_0001;
    localparam logic [15:0] ETY = 16'h88B5;

    logic        tx_clk = 1'b0;
    logic        reset_n;
    logic        conf_tx_en;
    logic        jumbo;
    logic        start;
    logic        stop;
    logic [13:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [31:0] cfg_cnt;
    logic [31:0] timestamp;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    eth_probe_gen_if mac ();

    eth_probe_gen dut (
        .tx_clk           (tx_clk),
        .reset_n          (reset_n),
        .conf_tx_en       (conf_tx_en),
        .conf_tx_jumbo_en (jumbo),
        .start            (start),
        .stop             (stop),
        .cfg_frame_len    (cfg_len),
        .cfg_gap          (cfg_gap),
        .cfg_frame_count  (cfg_cnt),
        .timestamp        (timestamp),
        .mac              (mac),
        .busy             (busy),
        .done             (done),
        .frames_sent      (frames_sent)
    );

    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) timestamp <= timestamp + 32'($urandom_range(1, 3));

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  fb[$];
    logic [7:0]  cur[$];
    int          fl[$];
    int          gq[$];
    logic [31:0] tsq[$];
    int          done_cnt = 0;
    int          n_starts = 0;
    int          low_cnt = 0;
    int          wcnt = 0;
    int          cur_dly = 0;
    int          fix_dly = 3;
    bit          rand_dly = 0;
    bit          noise = 0;
    bit          in_frame = 0;
    bit          waiting = 0;
    bit          have_prev = 0;

    // MAC side: acks byte 0 after a delay and collects frames and gaps.
    always @(negedge tx_clk) begin
        if (!reset_n) begin
            mac.mac_tx_ack = 1'b0;
            in_frame = 0;
            waiting = 0;
            have_prev = 0;
            cur.delete();
        end else begin
            mac.mac_tx_ack = 1'b0;
            if (done) done_cnt++;
            if (mac.mac_tx_dvld && !in_frame && !waiting) begin
                waiting = 1;
                wcnt = 0;
                n_starts++;
                cur_dly = rand_dly ? int'($urandom_range(0, 4)) : fix_dly;
                if (have_prev) gq.push_back(low_cnt);
            end
            if (waiting) begin
                if (wcnt >= cur_dly) begin
                    mac.mac_tx_ack = 1'b1;
                    tsq.push_back(timestamp);
                    cur.push_back(mac.mac_tx_data);
                    in_frame = 1;
                    waiting = 0;
                end else begin
                    wcnt++;
                end
            end else if (in_frame) begin
                if (mac.mac_tx_dvld) begin
                    cur.push_back(mac.mac_tx_data);
                    if (noise) mac.mac_tx_ack = 1'($urandom_range(0, 1));
                end else begin
                    fl.push_back(cur.size());
                    foreach (cur[i]) fb.push_back(cur[i]);
                    cur.delete();
                    in_frame = 0;
                    have_prev = 1;
                    low_cnt = 1;
                end
            end else if (!mac.mac_tx_dvld) begin
                low_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_byte(int i, int seq, logic [31:0] ts);
        logic [175:0] hdr;
        hdr = {DST, SRC, ETY, 32'(seq), ts};
        if (i < 22) return hdr[175 - 8*i -: 8];
        return 8'(i % 256);
    endfunction

    function automatic int model_len(int len, bit j);
        if (len < 60) return 60;
        if (j && len > 9014) return 9014;
        if (!j && len > 1514) return 1514;
        return len;
    endfunction

    task automatic launch(input int len, input bit j, input int gap, input int cnt);
        fl.delete(); fb.delete(); gq.delete(); tsq.delete();
        done_cnt = 0;
        have_prev = 0;
        cfg_len = 14'(len);
        jumbo = j;
        cfg_gap = 16'(gap);
        cfg_cnt = 32'(cnt);
        start = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge tx_clk);
            n++;
        end
        chk({tag, ".timeout"}, 64'(n < budget), 64'(1));
        repeat (3) @(negedge tx_clk);
    endtask

    task automatic finish(input string tag, input int len, input bit j,
                          input int gap, input int n);
        int el = model_len(len, j);
        int eg = (gap < 1) ? 1 : gap;
        int base = 0;
        wait_idle(tag, 40000);
        chk({tag, ".nframes"}, 64'(fl.size()), 64'(n));
        for (int k = 0; k < fl.size() && k < n; k++) begin
            int bad = -1;
            logic [7:0] g = 8'h0;
            logic [7:0] e = 8'h0;
            chk($sformatf("%s.len%0d", tag, k), 64'(fl[k]), 64'(el));
            for (int i = 0; i < fl[k]; i++) begin
                if (bad < 0 && fb[base + i] !== model_byte(i, k, tsq[k])) begin
                    bad = i;
                    g = fb[base + i];
                    e = model_byte(i, k, tsq[k]);
                end
            end
            chk($sformatf("%s.f%0d.byte%0d", tag, k, bad), 64'(g), 64'(e));
            base += fl[k];
        end
        chk({tag, ".ngaps"}, 64'(gq.size()), 64'(n - 1));
        foreach (gq[k]) chk($sformatf("%s.gap%0d", tag, k), 64'(gq[k]), 64'(eg));
        chk({tag, ".frames_sent"}, 64'(frames_sent), 64'(n));
        chk({tag, ".done"}, 64'(done_cnt), 64'(1));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        timestamp = $urandom;
        reset_n = 1'b0;
        conf_tx_en = 1'b1;
        jumbo = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_len = '0;
        cfg_gap = '0;
        cfg_cnt = '0;
        repeat (3) @(negedge tx_clk);
        chk("rst.dvld", 64'(mac.mac_tx_dvld), 64'(0));
        chk("rst.data", 64'(mac.mac_tx_data), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.frames", 64'(frames_sent), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge tx_clk);

        launch(40, 0, 5, 1);
        finish("short", 40, 0, 5, 1);
        chk("short.b22", 64'(fb[22]), 64'(8'h16));
        chk("short.ts", 64'({fb[18], fb[19], fb[20], fb[21]}), 64'(tsq[0]));

        rand_dly = 1;
        launch(64, 0, 12, 3);
        finish("multi", 64, 0, 12, 3);

        launch(2000, 0, 3, 1);
        finish("clamp_std", 2000, 0, 3, 1);
        launch(12000, 1, 3, 1);
        finish("clamp_jumbo", 12000, 1, 3, 1);

        launch(64, 0, 4, 0);
        n = 0;
        while (!(fl.size() == 4 && cur.size() >= 30) && n < 5000) begin
            @(negedge tx_clk);
            n++;
        end
        chk("stop.reach", 64'(n < 5000), 64'(1));
        stop = 1'b1;
        @(negedge tx_clk);
        stop = 1'b0;
        finish("stop", 64, 0, 4, 5);
        n_starts = 0;
        repeat (30) @(negedge tx_clk);
        chk("stop.quiet", 64'(n_starts), 64'(0));

        n_starts = 0;
        start = 1'b1;
        stop = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (5) @(negedge tx_clk);
        chk("ss.busy", 64'(busy), 64'(0));
        chk("ss.starts", 64'(n_starts), 64'(0));
        conf_tx_en = 1'b0;
        start = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
        repeat (5) @(negedge tx_clk);
        chk("txen.busy", 64'(busy), 64'(0));
        chk("txen.starts", 64'(n_starts), 64'(0));
        conf_tx_en = 1'b1;

        launch(64, 0, 3, 2);
        repeat (10) @(negedge tx_clk);
        cfg_len = 14'd200;
        cfg_cnt = 32'd5;
        cfg_gap = 16'd9;
        start = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
        finish("busy_start", 64, 0, 3, 2);

        noise = 1;
        for (int r = 0; r < 4; r++) begin
            int len = int'($urandom_range(0, 1700));
            bit j = 1'($urandom_range(0, 1));
            int gap = int'($urandom_range(0, 15));
            int cnt = int'($urandom_range(1, 3));
            launch(len, j, gap, cnt);
            finish($sformatf("rnd%0d", r), len, j, gap, cnt);
        end
        noise = 0;

        launch(300, 0, 2, 3);
        n = 0;
        while (cur.size() < 100 && n < 5000) begin
            @(negedge tx_clk);
            n++;
        end
        chk("rstmid.reach", 64'(n < 5000), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.dvld", 64'(mac.mac_tx_dvld), 64'(0));
        chk("rstmid.busy", 64'(busy), 64'(0));
        chk("rstmid.frames", 64'(frames_sent), 64'(0));
        @(negedge tx_clk);
        #2 reset_n = 1'b1;
        @(negedge tx_clk);
        launch(100, 0, 2, 2);
        finish("after_rst", 100, 0, 2, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
